serial_addsub_digits: RTL and testbench

Parametrised serial adder/subtractor that processes one DIGIT_W-bit digit pair per valid cycle, least-significant digit first, with framing by vld/last. It is the multi-bit, two-mode generation of the single-bit serial adder used in the sequential-basics datapath. It adds registered outputs with valid/last tagging, final carry and signed-overflow reporting, and a word-length guard.

---
 rtl/serial_addsub_digits.sv | 164 ++++++++++++++++
 tb/tb_serial_addsub_digits.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_digits.sv
// serial_addsub_digits: digit-serial adder/subtractor, LSD first, framed by vld/last.
//
// Each valid cycle consumes one DIGIT_W-bit digit pair (a, b) and produces one
// result digit on the following cycle. The mode (sub) and the initial carry are
// taken from the first digit of a word. The word closes on last. It also closes
// when it reaches MAX_DIGITS digits, and that forced close raises len_err.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN. When it is defined, ovf reports
// signed two's-complement overflow of the word. When it is not defined, ovf is
// tied to 0.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   vld        a, b, sub and last are valid this cycle
//   a, b       operand digits (DIGIT_W bits)
//   sub        0 = A+B, 1 = A-B (sampled on the first digit of a word)
//   last       final digit of the word
//   sum        result digit (registered)
//   sum_vld    sum holds a new digit
//   sum_last   sum is the final digit of the word
//   carry_out  carry out of the final digit (for subtraction, 1 = no borrow)
//   ovf        signed overflow of the whole word (valid with sum_last)
//   len_err    one-cycle pulse when a word is force-terminated at MAX_DIGITS
module serial_addsub_digits #(
    parameter int unsigned DIGIT_W    = 1,
    parameter int unsigned MAX_DIGITS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               sub,
    input  logic               last,
    output logic [DIGIT_W-1:0] sum,
    output logic               sum_vld,
    output logic               sum_last,
    output logic               carry_out,
    output logic               ovf,
    output logic               len_err
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int unsigned SUM_W = DIGIT_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic               carry, carry_nxt;
    logic               mode, mode_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic [DIGIT_W-1:0] sum_nxt;
    logic               sum_vld_nxt;
    logic               sum_last_nxt;
    logic               carry_out_nxt;
    logic               len_err_nxt;

    logic               first_dig;
    logic               mode_eff;
    logic               cin;
    logic [DIGIT_W-1:0] b_eff;
    logic [SUM_W-1:0]   full;
    logic [CNT_W-1:0]   cnt_inc;
    logic               force_end;
    logic               word_end;

    // Digit datapath: a first digit takes mode and carry-in from sub directly.
    always_comb begin
        first_dig = (state == IDLE);
        mode_eff  = first_dig ? sub : mode;
        cin       = first_dig ? sub : carry;
        b_eff     = mode_eff ? ~b : b;
        full      = SUM_W'(a) + SUM_W'(b_eff) + SUM_W'(cin);
        cnt_inc   = cnt + CNT_W'(1);
        force_end = !last && (cnt_inc == CNT_W'(MAX_DIGITS));
        word_end  = last || force_end;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        carry_nxt     = carry;
        mode_nxt      = mode;
        cnt_nxt       = cnt;
        sum_nxt       = sum;
        sum_vld_nxt   = 1'b0;
        sum_last_nxt  = 1'b0;
        carry_out_nxt = carry_out;
        len_err_nxt   = 1'b0;

        if (vld) begin
            mode_nxt      = mode_eff;
            sum_nxt       = full[DIGIT_W-1:0];
            sum_vld_nxt   = 1'b1;
            sum_last_nxt  = word_end;
            carry_out_nxt = full[DIGIT_W];
            len_err_nxt   = force_end;
            if (word_end) begin
                state_nxt = IDLE;
                carry_nxt = 1'b0;
                cnt_nxt   = '0;
            end else begin
                state_nxt = BUSY;
                carry_nxt = full[DIGIT_W];
                cnt_nxt   = cnt_inc;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            carry     <= 1'b0;
            mode      <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            sum_vld   <= 1'b0;
            sum_last  <= 1'b0;
            carry_out <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            carry     <= carry_nxt;
            mode      <= mode_nxt;
            cnt       <= cnt_nxt;
            sum       <= sum_nxt;
            sum_vld   <= sum_vld_nxt;
            sum_last  <= sum_last_nxt;
            carry_out <= carry_out_nxt;
            len_err   <= len_err_nxt;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic msb_cin;
    logic ovf_nxt;

    // The carry into the MSB is recovered from the MSB sum bit and its operands.
    always_comb begin
        msb_cin = full[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b_eff[DIGIT_W-1];
        ovf_nxt = ovf;
        if (vld) begin
            ovf_nxt = msb_cin ^ full[DIGIT_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_nxt;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_digits.sv
// Bench for serial_addsub_digits (DIGIT_W=4, MAX_DIGITS=6).
// The reference model accumulates whole operands as integers and evaluates each
// partial word arithmetically. Directed words pin the model to known values, and
// a random stream follows them.
module tb_serial_addsub_digits;

    localparam int unsigned W   = 4;
    localparam int unsigned MAX = 6;

    logic         clk;
    logic         rst;
    logic         vld;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         last;
    logic [W-1:0] sum;
    logic         sum_vld;
    logic         sum_last;
    logic         carry_out;
    logic         ovf;
    logic         len_err;

    serial_addsub_digits #(.DIGIT_W(W), .MAX_DIGITS(MAX)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .last      (last),
        .sum       (sum),
        .sum_vld   (sum_vld),
        .sum_last  (sum_last),
        .carry_out (carry_out),
        .ovf       (ovf),
        .len_err   (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: the operands of the open word, accumulated as integers.
    bit              m_open;
    bit              m_mode;
    int unsigned     m_k;
    longint unsigned m_a;
    longint unsigned m_b;

    // Expected registered outputs.
    logic [W-1:0] e_sum;
    bit           e_vld, e_last, e_cout, e_ovf, e_len;

    task automatic cmp(input string nm, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_mode = 0; m_k = 0; m_a = 0; m_b = 0;
        e_sum = '0; e_vld = 0; e_last = 0; e_cout = 0; e_ovf = 0; e_len = 0;
    endtask

    task automatic model_step(input bit v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                              input bit is, input bit il);
        int unsigned     nb;
        longint unsigned mask, beff, r;
        bit              sa, sb, sr;
        if (!v) begin
            e_vld = 0; e_last = 0; e_len = 0;
            return;
        end
        if (!m_open) begin
            m_open = 1; m_mode = is; m_k = 0; m_a = 0; m_b = 0;
        end
        m_a  = m_a | (64'(ia) << (m_k * W));
        m_b  = m_b | (64'(ib) << (m_k * W));
        m_k  = m_k + 1;
        nb   = m_k * W;
        mask = (64'd1 << nb) - 64'd1;
        beff = m_mode ? (~m_b & mask) : m_b;
        r    = m_a + beff + (m_mode ? 64'd1 : 64'd0);
        e_sum  = W'(r >> ((m_k - 1) * W));
        e_cout = ((r >> nb) & 64'd1) != 0;
        sa = ((m_a  >> (nb - 1)) & 64'd1) != 0;
        sb = ((beff >> (nb - 1)) & 64'd1) != 0;
        sr = ((r    >> (nb - 1)) & 64'd1) != 0;
        e_ovf  = OVF_ON && (sa == sb) && (sr != sa);
        e_len  = !il && (m_k == MAX);
        e_last = il || e_len;
        e_vld  = 1;
        if (e_last) m_open = 0;
    endtask

    task automatic check_outputs();
        cmp("sum_vld",  64'(sum_vld),  64'(e_vld));
        cmp("sum_last", 64'(sum_last), 64'(e_last));
        cmp("len_err",  64'(len_err),  64'(e_len));
        cmp("sum",      64'(sum),      64'(e_sum));
        if (e_last) begin
            cmp("carry_out", 64'(carry_out), 64'(e_cout));
            cmp("ovf",       64'(ovf),       64'(e_ovf));
        end
    endtask

    // Inputs are applied 1 time unit after an edge; outputs are checked 1 unit after the next edge.
    task automatic step(input bit v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input bit is, input bit il);
        vld = v; a = ia; b = ib; sub = is; last = il;
        model_step(v, ia, ib, is, il);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b0; vld = 0; a = '0; b = '0; sub = 0; last = 0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1;

        // 5 + 3, single digit.
        step(1, 4'h5, 4'h3, 0, 1);
        cmp("lit_5p3_sum", 64'(sum), 64'h8);
        cmp("lit_5p3_cout", 64'(carry_out), 64'h0);

        // 0x35 + 0x13 with idle gaps; a last with vld=0 must be ignored.
        step(1, 4'h5, 4'h3, 0, 0);
        step(0, 4'h0, 4'h0, 1, 1);
        cmp("lit_gap_vld", 64'(sum_vld), 64'h0);
        cmp("lit_gap_hold", 64'(sum), 64'h8);
        step(0, 4'h0, 4'h0, 0, 0);
        step(1, 4'h3, 4'h1, 1, 1);
        cmp("lit_gap_sum", 64'(sum), 64'h4);
        cmp("lit_gap_last", 64'(sum_last), 64'h1);

        // 0x05 - 0x03 = 0x02, no borrow.
        step(1, 4'h5, 4'h3, 1, 0);
        cmp("lit_sub_d0", 64'(sum), 64'h2);
        step(1, 4'h0, 4'h0, 0, 1);
        cmp("lit_sub_d1", 64'(sum), 64'h0);
        cmp("lit_sub_cout", 64'(carry_out), 64'h1);

        // 0x03 - 0x05 = 0xFE, borrow.
        step(1, 4'h3, 4'h5, 1, 0);
        cmp("lit_neg_d0", 64'(sum), 64'hE);
        step(1, 4'h0, 4'h0, 0, 1);
        cmp("lit_neg_d1", 64'(sum), 64'hF);
        cmp("lit_neg_cout", 64'(carry_out), 64'h0);

        // 0x7F + 0x01: signed overflow.
        step(1, 4'hF, 4'h1, 0, 0);
        cmp("lit_7f_d0", 64'(sum), 64'h0);
        step(1, 4'h7, 4'h0, 0, 1);
        cmp("lit_7f_d1", 64'(sum), 64'h8);
        cmp("lit_7f_ovf", 64'(ovf), OVF_ON ? 64'h1 : 64'h0);

        // 0xFF + 0x01: carry out, no overflow.
        step(1, 4'hF, 4'h1, 0, 0);
        step(1, 4'hF, 4'h0, 0, 1);
        cmp("lit_ff_d1", 64'(sum), 64'h0);
        cmp("lit_ff_cout", 64'(carry_out), 64'h1);
        cmp("lit_ff_ovf", 64'(ovf), 64'h0);

        // Forced termination at MAX digits, then a fresh word with sub=1.
        for (int i = 0; i < int'(MAX); i++) step(1, 4'h1, 4'h0, 0, 0);
        cmp("lit_force_len", 64'(len_err), 64'h1);
        cmp("lit_force_last", 64'(sum_last), 64'h1);
        step(1, 4'h1, 4'h0, 1, 0);
        cmp("lit_fresh_sum", 64'(sum), 64'h1);
        cmp("lit_fresh_len", 64'(len_err), 64'h0);
        step(1, 4'h0, 4'h0, 0, 1);

        // A last on the MAX-th digit is a normal last.
        for (int i = 0; i < int'(MAX) - 1; i++) step(1, 4'h2, 4'h1, 0, 0);
        step(1, 4'h2, 4'h1, 0, 1);
        cmp("lit_maxlast_len", 64'(len_err), 64'h0);

        // Reset in the middle of a word.
        step(1, 4'h9, 4'h9, 0, 0);
        step(1, 4'h9, 4'h9, 0, 0);
        vld = 0;
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        cmp("lit_rst_cout", 64'(carry_out), 64'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(1, 4'h1, 4'h1, 0, 1);
        cmp("lit_post_rst_sum", 64'(sum), 64'h2);
        cmp("lit_post_rst_cout", 64'(carry_out), 64'h0);

        // Random stream.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
